sweep_output_combiner: RTL

//  Downstream consumer of the triangle-wave sweep generator. Sums the sweep with the servo

---
 rtl/sweep_output_combiner_if.sv | 35 +++
 rtl/sweep_output_combiner.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sweep_output_combiner_if.sv
// Bundles the sweep combiner's data inputs, configuration and outputs.
// No latency of its own; it is a plain collection of wires.
// No backpressure: the combiner accepts a new sample on every clock.
interface sweep_output_combiner_if #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
);
  logic                 enable_in;
  logic [WIDTH-1:0]     sweep_in;
  logic [WIDTH-1:0]     servo_in;
  logic [WIDTH-1:0]     offset_in;
  logic [WIDTH-1:0]     min_lim_in;
  logic [WIDTH-1:0]     max_lim_in;
  logic                 slew_en_in;
  logic [WIDTH-1:0]     slew_step_in;
  logic [WIDTH-1:0]     signal_out;
  logic                 railed_out;
  logic                 turn_down_out;
  logic                 turn_up_out;
  logic [CNT_WIDTH-1:0] sweep_count_out;

  // Source side: drives samples and configuration, observes the DAC word and trigger outputs.
  modport master (
    output enable_in, sweep_in, servo_in, offset_in, min_lim_in, max_lim_in,
           slew_en_in, slew_step_in,
    input  signal_out, railed_out, turn_down_out, turn_up_out, sweep_count_out
  );

  // Combiner side.
  modport slave (
    input  enable_in, sweep_in, servo_in, offset_in, min_lim_in, max_lim_in,
           slew_en_in, slew_step_in,
    output signal_out, railed_out, turn_down_out, turn_up_out, sweep_count_out
  );
endinterface

// File: rtl/sweep_output_combiner.sv
// Sums sweep + servo + offset, clamps to rails, slew-limits into the DAC word; flags sweep turnarounds.
// Latency: 3 cycles input -> signal_out/railed_out (slew off); turnaround pulses 1 cycle after the sample edge.
// No backpressure: a new sample is accepted every cycle and outputs are never stalled.
module sweep_output_combiner #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input logic                   clk_in,
  input logic                   rst_n_in,
  sweep_output_combiner_if.slave bus
);

  // Sum width: three WIDTH-bit signed terms cannot overflow WIDTH+2 bits.
  localparam int SW = WIDTH + 2;
  // Difference width for the slew stage: two WIDTH-bit signed terms need WIDTH+1 bits.
  localparam int DW = WIDTH + 1;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  // Signed views of the input words.
  logic signed [WIDTH-1:0] sweep_s;
  logic signed [WIDTH-1:0] servo_s;
  logic signed [WIDTH-1:0] offset_s;
  logic signed [WIDTH-1:0] min_s;
  logic signed [WIDTH-1:0] max_s;

  assign sweep_s  = bus.sweep_in;
  assign servo_s  = bus.servo_in;
  assign offset_s = bus.offset_in;
  assign min_s    = bus.min_lim_in;
  assign max_s    = bus.max_lim_in;

  // ---------------------------------------------------------------------------
  // Stage 1: full-precision sum. Enable and rails travel with the sum so the
  // clamp in stage 2 always sees the settings that belonged to the same sample.
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0]    sum_d;
  logic signed [SW-1:0]    sum_q;
  logic                    en_q;
  logic signed [WIDTH-1:0] min_q;
  logic signed [WIDTH-1:0] max_q;

  assign sum_d = $signed({{2{sweep_s[WIDTH-1]}},  sweep_s})
               + $signed({{2{servo_s[WIDTH-1]}},  servo_s})
               + $signed({{2{offset_s[WIDTH-1]}}, offset_s});

  // Register the sum together with its enable and rail settings.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sum_q <= '0;
      en_q  <= 1'b0;
      min_q <= '0;
      max_q <= '0;
    end else begin
      sum_q <= sum_d;
      en_q  <= bus.enable_in;
      min_q <= min_s;
      max_q <= max_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: clamp to the rails. An inverted rail pair pins the target to the
  // lower rail and reports railed. When disabled the target is a hard 0 that
  // is not subjected to the rails.
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] min_x;
  logic signed [SW-1:0] max_x;
  logic [WIDTH-1:0]     target_d;
  logic                 railed_d;
  logic [WIDTH-1:0]     target_q;
  logic                 railed_q;

  assign min_x = $signed({{2{min_q[WIDTH-1]}}, min_q});
  assign max_x = $signed({{2{max_q[WIDTH-1]}}, max_q});

  // Select the clamped target and whether a rail was hit.
  always_comb begin
    target_d = '0;
    railed_d = 1'b0;
    if (en_q) begin
      if (min_q > max_q) begin
        target_d = min_q;
        railed_d = 1'b1;
      end else if (sum_q > max_x) begin
        target_d = max_q;
        railed_d = 1'b1;
      end else if (sum_q < min_x) begin
        target_d = min_q;
        railed_d = 1'b1;
      end else begin
        target_d = sum_q[WIDTH-1:0];
      end
    end
  end

  // Register the clamped target.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      target_q <= '0;
      railed_q <= 1'b0;
    end else begin
      target_q <= target_d;
      railed_q <= railed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: slew limiter. When the remaining distance exceeds the step we move
  // by exactly one step (the result then lies strictly between the current
  // output and the target, so plain WIDTH-bit arithmetic cannot wrap);
  // otherwise we land on the target, which rules out overshoot.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]     sig_d;
  logic [WIDTH-1:0]     sig_q;
  logic                 railed_out_q;
  logic signed [DW-1:0] diff;
  logic [DW-1:0]        mag;
  logic [DW-1:0]        step_x;

  assign diff   = $signed({target_q[WIDTH-1], target_q}) - $signed({sig_q[WIDTH-1], sig_q});
  assign mag    = diff[DW-1] ? DW'(-diff) : DW'(diff);
  assign step_x = {1'b0, bus.slew_step_in};

  // Next DAC word: direct target, or one bounded step toward it.
  always_comb begin
    sig_d = target_q;
    if (bus.slew_en_in && (mag > step_x)) begin
      if (diff[DW-1]) begin
        sig_d = sig_q - bus.slew_step_in;
      end else begin
        sig_d = sig_q + bus.slew_step_in;
      end
    end
  end

  // Register the DAC word; railed is delayed one more stage to stay aligned with it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sig_q        <= '0;
      railed_out_q <= 1'b0;
    end else begin
      sig_q        <= sig_d;
      railed_out_q <= railed_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Turnaround detector: compares each sweep sample with the previous one.
  // Equal samples keep the current direction since the sweep may dwell.
  // ---------------------------------------------------------------------------
  dir_t                    dir_q;
  dir_t                    dir_d;
  logic signed [WIDTH-1:0] prev_q;
  logic                    down_d;
  logic                    up_d;
  logic                    down_q;
  logic                    up_q;
  logic [CNT_WIDTH-1:0]    cnt_d;
  logic [CNT_WIDTH-1:0]    cnt_q;

  // Direction state, previous sample, registered pulses and cycle count.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dir_q  <= DIR_IDLE;
      prev_q <= '0;
      down_q <= 1'b0;
      up_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      dir_q  <= dir_d;
      prev_q <= sweep_s;
      down_q <= down_d;
      up_q   <= up_d;
      cnt_q  <= cnt_d;
    end
  end

  // Next direction, turnaround pulses and count update; disable parks everything.
  always_comb begin
    dir_d  = dir_q;
    down_d = 1'b0;
    up_d   = 1'b0;
    cnt_d  = cnt_q;
    if (!bus.enable_in) begin
      dir_d = DIR_IDLE;
      cnt_d = '0;
    end else if (sweep_s > prev_q) begin
      dir_d = DIR_UP;
      if (dir_q == DIR_DOWN) begin
        up_d  = 1'b1;
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end else if (sweep_s < prev_q) begin
      dir_d = DIR_DOWN;
      if (dir_q == DIR_UP) begin
        down_d = 1'b1;
      end
    end
  end

  assign bus.signal_out      = sig_q;
  assign bus.railed_out      = railed_out_q;
  assign bus.turn_down_out   = down_q;
  assign bus.turn_up_out     = up_q;
  assign bus.sweep_count_out = cnt_q;

endmodule
